pe_array_4x4: RTL and testbench

Weight-stationary 4x4 systolic MAC array for the accelerator datapath.
- Activations enter on the left edge, one per row, and move right one PE per cycle.
- Partial sums enter at the top, one per column, and move down one PE per cycle.
- Each column's bottom partial sum feeds a per-column output accumulator, which drives psum_out_flat.

---
 rtl/pe_array_4x4.sv | 139 +++++++++++++
 tb/tb_pe_array_4x4.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_4x4.sv
// Weight-stationary systolic MAC array.
//
// Activations enter on the left edge (one lane per row) and shift right one PE per
// enabled cycle. Partial sums enter at the top (one lane per column) and shift down
// one PE per enabled cycle, picking up act * weight at each PE. The bottom partial
// sum of each column is accumulated into a per-column output register.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset, clears all state
//   enable         advance PE pipeline and output accumulators
//   load_weight    capture weight_in_flat (row r broadcast to all columns) and
//                  clear the output accumulators; independent of enable
//   quantize_mode  0: unsigned operands, wrapping sums
//                  1: signed operands, output saturated to [-128, 127]
//   act_in_flat    left-edge activations, lane r = [r*DATA_WIDTH +: DATA_WIDTH]
//   psum_in_flat   top-edge partial sums, lane c = [c*ACC_WIDTH +: ACC_WIDTH]
//   weight_in_flat per-row weights, lane r = [r*DATA_WIDTH +: DATA_WIDTH]
//   psum_out_flat  registered output accumulators, lane c as for psum_in_flat
module pe_array_4x4 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       load_weight,
    input  logic                       quantize_mode,
    input  logic [DATA_WIDTH*ROWS-1:0] act_in_flat,
    input  logic [ACC_WIDTH*COLS-1:0]  psum_in_flat,
    input  logic [DATA_WIDTH*ROWS-1:0] weight_in_flat,
    output logic [ACC_WIDTH*COLS-1:0]  psum_out_flat
);

    // Saturation bounds carried one bit wider than the accumulator so the
    // signed sum of two accumulator-width values never overflows.
    localparam logic signed [ACC_WIDTH:0] SatMax = 127;
    localparam logic signed [ACC_WIDTH:0] SatMin = -128;

    logic [DATA_WIDTH-1:0] w_q  [ROWS][COLS];
    logic [DATA_WIDTH-1:0] a_q  [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  p_q  [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  o_q  [COLS];

    logic [DATA_WIDTH-1:0] a_in [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  p_in [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  p_d  [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  o_d  [COLS];

    // Extending both operands to ACC_WIDTH first makes the truncated product
    // equal to the full signed (or unsigned) product modulo 2^ACC_WIDTH.
    function automatic logic [ACC_WIDTH-1:0] mac_product(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] w,
        input logic                  sgn
    );
        logic [ACC_WIDTH-1:0] a_x;
        logic [ACC_WIDTH-1:0] w_x;
        a_x = {{(ACC_WIDTH-DATA_WIDTH){sgn & a[DATA_WIDTH-1]}}, a};
        w_x = {{(ACC_WIDTH-DATA_WIDTH){sgn & w[DATA_WIDTH-1]}}, w};
        return a_x * w_x;
    endfunction

    function automatic logic [ACC_WIDTH-1:0] acc_next(
        input logic [ACC_WIDTH-1:0] acc,
        input logic [ACC_WIDTH-1:0] add,
        input logic                 sgn
    );
        logic signed [ACC_WIDTH:0] sum;
        sum = $signed({acc[ACC_WIDTH-1], acc}) + $signed({add[ACC_WIDTH-1], add});
        if (!sgn) begin
            return acc + add;
        end else if (sum > SatMax) begin
            return SatMax[ACC_WIDTH-1:0];
        end else if (sum < SatMin) begin
            return SatMin[ACC_WIDTH-1:0];
        end
        return sum[ACC_WIDTH-1:0];
    endfunction

    // Neighbour wiring and per-PE MAC.
    for (genvar r = 0; r < ROWS; r++) begin : gen_row
        for (genvar c = 0; c < COLS; c++) begin : gen_col
            if (c == 0) begin : gen_act_edge
                assign a_in[r][c] = act_in_flat[r*DATA_WIDTH +: DATA_WIDTH];
            end else begin : gen_act_link
                assign a_in[r][c] = a_q[r][c-1];
            end
            if (r == 0) begin : gen_psum_edge
                assign p_in[r][c] = psum_in_flat[c*ACC_WIDTH +: ACC_WIDTH];
            end else begin : gen_psum_link
                assign p_in[r][c] = p_q[r-1][c];
            end
            assign p_d[r][c] = p_in[r][c] + mac_product(a_in[r][c], w_q[r][c], quantize_mode);
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : gen_out
        assign o_d[c] = acc_next(o_q[c], p_q[ROWS-1][c], quantize_mode);
        assign psum_out_flat[c*ACC_WIDTH +: ACC_WIDTH] = o_q[c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    w_q[r][c] <= '0;
                    a_q[r][c] <= '0;
                    p_q[r][c] <= '0;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                o_q[c] <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (load_weight) begin
                        w_q[r][c] <= weight_in_flat[r*DATA_WIDTH +: DATA_WIDTH];
                    end
                    if (enable) begin
                        a_q[r][c] <= a_in[r][c];
                        p_q[r][c] <= p_d[r][c];
                    end
                end
            end
            for (int c = 0; c < COLS; c++) begin
                if (load_weight) begin
                    o_q[c] <= '0;
                end else if (enable) begin
                    o_q[c] <= o_d[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_array_4x4.sv
// Self-checking bench for pe_array_4x4: directed scenarios followed by random
// stimulus, all compared every cycle against a wavefront-formula reference model.
module tb_pe_array_4x4;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int R  = 4;
    localparam int C  = 4;

    logic           clk;
    logic           rst;
    logic           enable;
    logic           load_weight;
    logic           quantize_mode;
    logic [DW*R-1:0] act_in_flat;
    logic [AW*C-1:0] psum_in_flat;
    logic [DW*R-1:0] weight_in_flat;
    logic [AW*C-1:0] psum_out_flat;

    pe_array_4x4 #(
        .DATA_WIDTH(DW),
        .ACC_WIDTH (AW),
        .ROWS      (R),
        .COLS      (C)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .load_weight   (load_weight),
        .quantize_mode (quantize_mode),
        .act_in_flat   (act_in_flat),
        .psum_in_flat  (psum_in_flat),
        .weight_in_flat(weight_in_flat),
        .psum_out_flat (psum_out_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one history entry per enabled edge since the last reset.
    // The bottom psum of column c after enabled edge n is the wavefront sum
    //   psum_in[n-3][c] + sum_r act[n-(3-r)-c][r] * W_at(n-(3-r))[r]
    // with out-of-range history treated as zero (reset contents).
    logic [DW*R-1:0] act_h  [$];
    logic [AW*C-1:0] psum_h [$];
    logic [DW*R-1:0] w_h    [$];
    bit              mode_h [$];
    logic [DW*R-1:0] cur_w;
    logic [AW-1:0]   o_m [C];

    function automatic longint prod(logic [7:0] a, logic [7:0] w, bit m);
        if (m) return longint'($signed(a)) * longint'($signed(w));
        return longint'(a) * longint'(w);
    endfunction

    function automatic logic [31:0] p3_at(int n, int c);
        longint s;
        s = 0;
        if (n < 0) return 32'd0;
        if (n - 3 >= 0) s += longint'(psum_h[n-3][c*AW +: AW]);
        for (int r = 0; r < R; r++) begin
            int e;
            int ea;
            e  = n - (R - 1 - r);
            ea = e - c;
            if (e >= 0 && ea >= 0)
                s += prod(act_h[ea][r*DW +: DW], w_h[e][r*DW +: DW], mode_h[e]);
        end
        return s[31:0];
    endfunction

    function automatic logic [31:0] acc_model(logic [31:0] o, logic [31:0] p, bit m);
        longint s;
        if (!m) return o + p;
        s = longint'($signed(o)) + longint'($signed(p));
        if (s > 127) return 32'd127;
        if (s < -128) return 32'hFFFF_FF80;
        return s[31:0];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the model from the inputs sampled at that edge,
    // then compare every output lane.
    task automatic step(string tag);
        logic [31:0] p3pre;
        @(posedge clk);
        if (rst) begin
            act_h.delete();
            psum_h.delete();
            w_h.delete();
            mode_h.delete();
            cur_w = '0;
            for (int c = 0; c < C; c++) o_m[c] = '0;
        end else begin
            for (int c = 0; c < C; c++) begin
                p3pre = p3_at(act_h.size() - 1, c);
                if (load_weight) o_m[c] = '0;
                else if (enable) o_m[c] = acc_model(o_m[c], p3pre, quantize_mode);
            end
            if (enable) begin
                act_h.push_back(act_in_flat);
                psum_h.push_back(psum_in_flat);
                w_h.push_back(cur_w);
                mode_h.push_back(quantize_mode);
            end
            if (load_weight) cur_w = weight_in_flat;
        end
        #1;
        for (int c = 0; c < C; c++)
            check($sformatf("%s lane%0d", tag, c), psum_out_flat[c*AW +: AW], o_m[c]);
    endtask

    task automatic expect_all(string tag, logic [31:0] exp);
        for (int c = 0; c < C; c++)
            check($sformatf("%s final lane%0d", tag, c), psum_out_flat[c*AW +: AW], exp);
    endtask

    task automatic load(logic [DW*R-1:0] w);
        weight_in_flat = w;
        load_weight    = 1'b1;
        act_in_flat    = '0;
        step("load");
        load_weight    = 1'b0;
    endtask

    // Row r carries v on the r-th cycle only.
    task automatic stream(logic [7:0] v, int n, string tag);
        for (int t = 0; t < n; t++) begin
            act_in_flat = '0;
            if (t < R) act_in_flat[t*DW +: DW] = v;
            step(tag);
        end
        act_in_flat = '0;
    endtask

    initial begin
        int ecnt;

        // Reset with every input driven nonzero.
        rst            = 1'b1;
        enable         = 1'b1;
        load_weight    = 1'b1;
        quantize_mode  = 1'b1;
        act_in_flat    = 32'hFFFF_FFFF;
        psum_in_flat   = {4{32'h1234_5678}};
        weight_in_flat = 32'h7F7F_7F7F;
        step("reset");
        step("reset");
        expect_all("reset", 32'd0);

        // Weights were cleared: nonzero activations produce nothing.
        rst           = 1'b0;
        load_weight   = 1'b0;
        quantize_mode = 1'b0;
        psum_in_flat  = '0;
        act_in_flat   = 32'h0505_0505;
        for (int i = 0; i < 10; i++) step("zero_weight");
        act_in_flat   = '0;
        for (int i = 0; i < 4; i++) step("drain");
        expect_all("zero_weight", 32'd0);

        // Basic column: 10 * (2+3+4+5).
        load(32'h0504_0302);
        stream(8'd10, 20, "basic");
        expect_all("basic", 32'd140);

        // Same stream with a three-cycle stall after the second row.
        load(32'h0504_0302);
        ecnt = 0;
        for (int t = 0; t < 23; t++) begin
            enable      = !(t >= 2 && t <= 4);
            act_in_flat = '0;
            if (enable && ecnt < R) act_in_flat[ecnt*DW +: DW] = 8'd10;
            if (enable) ecnt++;
            step("hold");
        end
        enable      = 1'b1;
        act_in_flat = '0;
        expect_all("hold", 32'd140);

        // Reload clears the accumulators: 7 * 4.
        load(32'h0101_0101);
        stream(8'd7, 20, "reload");
        expect_all("reload", 32'd28);

        // Signed mode: 10 * (-2+3+4+5), then saturation.
        quantize_mode = 1'b1;
        load(32'h0504_03FE);
        stream(8'd10, 20, "signed");
        expect_all("signed", 32'd100);
        load(32'h7F7F_7F7F);
        stream(8'd127, 20, "saturate");
        expect_all("saturate", 32'd127);

        // Psum injection into column 0 only.
        quantize_mode = 1'b0;
        load(32'h0101_0101);
        psum_in_flat  = '0;
        psum_in_flat[0 +: AW] = 32'd1000;
        step("inject");
        psum_in_flat  = '0;
        for (int i = 0; i < 20; i++) step("inject");
        check("inject final lane0", psum_out_flat[0 +: AW], 32'd1000);
        check("inject final lane1", psum_out_flat[AW +: AW], 32'd0);
        check("inject final lane2", psum_out_flat[2*AW +: AW], 32'd0);
        check("inject final lane3", psum_out_flat[3*AW +: AW], 32'd0);

        // Random traffic, including mid-stream reset, reloads, stalls and mode flips.
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(63) == 0);
            load_weight    = ($urandom_range(15) == 0);
            enable         = ($urandom_range(3) != 0);
            if ($urandom_range(31) == 0) quantize_mode = ~quantize_mode;
            act_in_flat    = $urandom;
            weight_in_flat = $urandom;
            for (int c = 0; c < C; c++)
                psum_in_flat[c*AW +: AW] = ($urandom_range(1) != 0) ? $urandom
                                                                    : $urandom_range(255);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
